// File: rtl/arbiter_types.sv
// Shared types for the physical-memory line-port arbiter.
// Imported by the arbiter top and its bench.
package arbiter_types;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the arbiter performance counters.
// Holds at all-ones once reached.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one 256-bit pmem line port between
// the I-cache and D-cache, one whole line transaction at a time.
module pmem_arbiter
    import arbiter_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [CNT_W-1:0]  cnt_i_grant,
    output logic [CNT_W-1:0]  cnt_d_grant,
    output logic [CNT_W-1:0]  cnt_conflict
);

    arb_state_t        state_q, state_d;
    requester_t        last_q, last_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic conflict;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // Ties go to whoever did not win last; a lone requester always wins.
    assign grant_i = (state_q == IDLE) && i_req &&
                     (!d_req || (last_q == REQ_D));
    assign grant_d = (state_q == IDLE) && d_req && !grant_i;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        conflict = 1'b0;
        unique case (state_q)
            IDLE: begin
                conflict = i_req && d_req;
                unique case (1'b1)
                    grant_i: begin
                        state_d = I_BUSY;
                        last_d  = REQ_I;
                        rd_d    = 1'b1;
                        wr_d    = 1'b0;
                        addr_d  = {i_address[31:OFFSET_W],
                                   {OFFSET_W{1'b0}}};
                    end
                    grant_d: begin
                        state_d = D_BUSY;
                        last_d  = REQ_D;
                        rd_d    = d_read & ~d_write;
                        wr_d    = d_write;
                        addr_d  = {d_address[31:OFFSET_W],
                                   {OFFSET_W{1'b0}}};
                        if (d_write) begin
                            wdata_d = d_wdata;
                        end
                    end
                    default: ;
                endcase
            end
            I_BUSY: begin
                conflict = d_req;
                if (pmem_resp) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            D_BUSY: begin
                conflict = i_req;
                if (pmem_resp) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= REQ_D;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_resp  = (state_q == I_BUSY) && pmem_resp;
    assign d_resp  = (state_q == D_BUSY) && pmem_resp;
    assign i_rdata = i_resp ? pmem_rdata : '0;
    assign d_rdata = d_resp ? pmem_rdata : '0;

    sat_counter #(.W(CNT_W)) u_cnt_i (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_i),
        .count (cnt_i_grant)
    );

    sat_counter #(.W(CNT_W)) u_cnt_d (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_d),
        .count (cnt_d_grant)
    );

    sat_counter #(.W(CNT_W)) u_cnt_c (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (conflict),
        .count (cnt_conflict)
    );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: stimulus queues expected port
// commands and responses, a negedge monitor pops and compares them.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_read, d_read, d_write, pmem_resp;
    logic [31:0]  i_address, d_address;
    logic [255:0] d_wdata, pmem_rdata;

    logic [255:0] i_rdata, d_rdata, pmem_wdata;
    logic         i_resp, d_resp, pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [31:0]  cnt_i_grant, cnt_d_grant, cnt_conflict;

    logic [255:0] s_i_rdata, s_d_rdata, s_pmem_wdata;
    logic         s_i_resp, s_d_resp, s_pmem_read, s_pmem_write;
    logic [31:0]  s_pmem_address;
    logic [1:0]   s_cnt_i, s_cnt_d, s_cnt_c;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } port_t;

    typedef struct {
        logic         is_i;
        logic [255:0] data;
    } resp_t;

    port_t port_q[$];
    resp_t resp_q[$];
    port_t cur;
    logic  have_cur = 1'b0;
    logic  prev_cmd = 1'b0;

    always #5 clk = ~clk;

    pmem_arbiter #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write),
        .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .cnt_i_grant(cnt_i_grant), .cnt_d_grant(cnt_d_grant),
        .cnt_conflict(cnt_conflict)
    );

    pmem_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address),
        .i_rdata(s_i_rdata), .i_resp(s_i_resp),
        .d_read(d_read), .d_write(d_write),
        .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(s_d_rdata), .d_resp(s_d_resp),
        .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
        .pmem_address(s_pmem_address), .pmem_wdata(s_pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .cnt_i_grant(s_cnt_i), .cnt_d_grant(s_cnt_d),
        .cnt_conflict(s_cnt_c)
    );

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_port(input logic rd, input logic wr,
                             input logic [31:0] a, input logic [255:0] w);
        port_t p;
        p.rd = rd; p.wr = wr; p.addr = a; p.wdata = w;
        port_q.push_back(p);
    endtask

    task automatic push_resp(input logic is_i, input logic [255:0] d);
        resp_t r;
        r.is_i = is_i; r.data = d;
        resp_q.push_back(r);
    endtask

    // Memory side: wait for a command, answer after lat busy cycles.
    task automatic serve(input int lat, input logic [255:0] data);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (pmem_read || pmem_write) seen = 1'b1;
            else tick();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL serve_timeout: got no command want command");
            return;
        end
        repeat (lat) tick();
        pmem_resp  = 1'b1;
        pmem_rdata = data;
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
    endtask

    task automatic do_reset();
        i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
        i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cmd = 1'b0;
            have_cur = 1'b0;
        end else begin
            if ((pmem_read || pmem_write) && !prev_cmd) begin
                if (port_q.size() == 0) begin
                    checks++;
                    errors++;
                    have_cur = 1'b0;
                    $display("FAIL unexpected_cmd: got %b%b want none",
                             pmem_read, pmem_write);
                end else begin
                    cur = port_q.pop_front();
                    have_cur = 1'b1;
                end
            end
            if ((pmem_read || pmem_write) && have_cur) begin
                chk("port_rd", pmem_read, cur.rd);
                chk("port_wr", pmem_write, cur.wr);
                chk("port_addr", pmem_address, cur.addr);
                if (cur.wr) chk("port_wdata", pmem_wdata, cur.wdata);
            end
            if (i_resp || d_resp) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got i=%b d=%b want none",
                             i_resp, d_resp);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    chk("i_resp", i_resp, r.is_i);
                    chk("d_resp", d_resp, !r.is_i);
                    chk("i_rdata", i_rdata, r.is_i ? r.data : '0);
                    chk("d_rdata", d_rdata, r.is_i ? '0 : r.data);
                end
            end else begin
                chk("i_rdata_idle", i_rdata, '0);
                chk("d_rdata_idle", d_rdata, '0);
            end
            prev_cmd = pmem_read || pmem_write;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] a5, wd, wd2;
        a5  = {32{8'hA5}};
        wd  = {4{64'h0123_4567_89AB_CDEF}};
        wd2 = {8{32'hFEED_BEEF}};

        do_reset();
        chk("rst_rd", pmem_read, 0);
        chk("rst_wr", pmem_write, 0);
        chk("rst_addr", pmem_address, 0);
        chk("rst_wdata", pmem_wdata, 0);
        chk("rst_resp", {i_resp, d_resp}, 0);
        chk("rst_cnt", {cnt_i_grant, cnt_d_grant, cnt_conflict}, 0);

        // I read alone, then four more to saturate the 2-bit counter
        i_read = 1; i_address = 32'h0000_1234;
        push_port(1, 0, 32'h0000_1220, '0);
        push_resp(1, a5);
        tick();
        chk("i_first_cmd_latency", pmem_read, 1);
        serve(2, a5);
        i_read = 0;
        chk("i_cnt1", cnt_i_grant, 1);
        chk("i_cnt_d", cnt_d_grant, 0);
        chk("i_conflict0", cnt_conflict, 0);
        for (int k = 1; k < 5; k++) begin
            tick();
            i_read = 1;
            i_address = 32'h0000_1000 + 32'(k * 32);
            push_port(1, 0, 32'h0000_1000 + 32'(k * 32), '0);
            push_resp(1, {32{8'(k)}});
            serve(0, {32{8'(k)}});
            i_read = 0;
        end
        chk("cnt_i5", cnt_i_grant, 5);
        chk("sat_cnt_i", s_cnt_i, 2'd3);

        // D writeback with inputs scrambled mid-transaction
        do_reset();
        d_write = 1; d_address = 32'h8000_0040; d_wdata = wd;
        push_port(0, 1, 32'h8000_0040, wd);
        push_resp(0, a5);
        tick();
        d_write = 0; d_read = 1; d_address = 32'hFFFF_FFFF; d_wdata = '1;
        i_read = 0;
        serve(2, a5);
        d_read = 0;
        chk("d_cnt1", cnt_d_grant, 1);
        chk("d_cnt_i0", cnt_i_grant, 0);
        tick();
        // read+write together is a write; address low bits masked
        d_read = 1; d_write = 1; d_address = 32'h8000_009F; d_wdata = wd2;
        push_port(0, 1, 32'h8000_0080, wd2);
        push_resp(0, ~a5);
        serve(1, ~a5);
        d_read = 0; d_write = 0;
        chk("d_cnt2", cnt_d_grant, 2);

        // simultaneous from reset: I first, then D
        do_reset();
        i_read = 1; i_address = 32'h0000_0A00;
        d_write = 1; d_address = 32'h0000_0B00; d_wdata = wd;
        push_port(1, 0, 32'h0000_0A00, '0);
        push_resp(1, {8{32'h1111_2222}});
        push_port(0, 1, 32'h0000_0B00, wd);
        push_resp(0, {8{32'h3333_4444}});
        serve(3, {8{32'h1111_2222}});
        i_read = 0;
        serve(2, {8{32'h3333_4444}});
        d_write = 0;
        chk("sim_conflict", cnt_conflict, 5);
        chk("sim_cnt_i", cnt_i_grant, 1);
        chk("sim_cnt_d", cnt_d_grant, 1);

        // sustained contention alternates I,D,I,D,I,D
        do_reset();
        i_read = 1; i_address = 32'h0000_3000;
        d_read = 1; d_address = 32'h0000_5000;
        for (int k = 0; k < 6; k++) begin
            push_port(1, 0, (k % 2 == 0) ? 32'h0000_3000 : 32'h0000_5000,
                      '0);
            push_resp(k % 2 == 0, {8{32'hC0DE_0000 + 32'(k)}});
        end
        for (int k = 0; k < 6; k++) serve(1, {8{32'hC0DE_0000 + 32'(k)}});
        i_read = 0; d_read = 0;
        chk("rr_cnt_i", cnt_i_grant, 3);
        chk("rr_cnt_d", cnt_d_grant, 3);
        chk("rr_conflict", cnt_conflict, 18);

        // reset during D_BUSY, late pmem_resp ignored, next tie to I
        do_reset();
        d_read = 1; d_address = 32'h4000_0100;
        push_port(1, 0, 32'h4000_0100, '0);
        tick();
        tick();
        chk("mid_busy_cmd", pmem_read, 1);
        rst_n = 0; d_read = 0;
        #1;
        chk("mid_rst_cmd", {pmem_read, pmem_write}, 0);
        chk("mid_rst_addr", pmem_address, 0);
        chk("mid_rst_resp", {i_resp, d_resp}, 0);
        chk("mid_rst_cnt", {cnt_i_grant, cnt_d_grant, cnt_conflict}, 0);
        pmem_resp = 1; pmem_rdata = '1;
        tick();
        rst_n = 1;
        #1;
        chk("late_resp", {i_resp, d_resp}, 0);
        chk("late_rdata", d_rdata, 0);
        tick();
        pmem_resp = 0; pmem_rdata = '0;
        i_read = 1; i_address = 32'h0000_0700;
        d_read = 1; d_address = 32'h0000_0900;
        push_port(1, 0, 32'h0000_0700, '0);
        push_resp(1, wd);
        push_port(1, 0, 32'h0000_0900, '0);
        push_resp(0, wd2);
        serve(1, wd);
        i_read = 0;
        serve(1, wd2);
        d_read = 0;
        chk("post_rst_cnt_i", cnt_i_grant, 1);
        tick();
        tick();

        chk("port_q_empty", port_q.size(), 0);
        chk("resp_q_empty", resp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
